io_input_ctrl: RTL and testbench

Memory-mapped input device for the single-cycle processor: synchronizes and debounces board KEY[3:0] and SW[9:0] and exposes data and control/status registers on the processor's data-memory bus. It is the read-side complement of the LEDR/HEX output path. Change events set sticky Ready/Overrun flags and optionally raise an interrupt. Instantiated beside data memory in the Project2 top level.

---
 rtl/io_input_ctrl_pkg.sv | 41 ++++
 rtl/io_input_ctrl_debounce.sv | 71 +++++++
 rtl/io_input_ctrl.sv | 150 +++++++++++++++
 tb/tb_io_input_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_input_ctrl_pkg.sv
// io_input_ctrl_pkg
//   Shared constants for the memory-mapped input device: bus width,
//   default register addresses, CTRL bit positions and bank indices.
//   Also provides the CTRL flag bundle type and a helper that packs it
//   into a bus word.
package io_input_ctrl_pkg;

  localparam int DBITS_DEFAULT = 32;

  localparam logic [31:0] ADDR_KDATA_DEFAULT = 32'hF000_0010;
  localparam logic [31:0] ADDR_KCTRL_DEFAULT = 32'hF000_0110;
  localparam logic [31:0] ADDR_SDATA_DEFAULT = 32'hF000_0014;
  localparam logic [31:0] ADDR_SCTRL_DEFAULT = 32'hF000_0114;

  // CTRL register bit positions (identical for both banks)
  localparam int READY_BIT   = 0;
  localparam int OVERRUN_BIT = 2;
  localparam int IE_BIT      = 4;

  // Bank indices used to address per-bank arrays in the top level
  localparam int BANK_KEY = 0;
  localparam int BANK_SW  = 1;
  localparam int NBANKS   = 2;

  typedef struct packed {
    logic ie;
    logic overrun;
    logic ready;
  } ctrl_flags_t;

  // Pack the flags into the low byte of a CTRL read word; unused bits are 0.
  function automatic logic [7:0] ctrl_byte(input ctrl_flags_t f);
    logic [7:0] b;
    b              = 8'h00;
    b[READY_BIT]   = f.ready;
    b[OVERRUN_BIT] = f.overrun;
    b[IE_BIT]      = f.ie;
    return b;
  endfunction

endpackage

// File: rtl/io_input_ctrl_debounce.sv
// io_debounce
//   Two-flop synchronizer followed by a whole-vector debouncer. A new
//   value is committed to o_data once the synchronized input has been
//   stable for DEBOUNCE_CYCLES cycles (the cycle that loads the candidate
//   counts as the first). End-to-end latency from a stable raw input to
//   o_data is 2 + DEBOUNCE_CYCLES clocks. DEBOUNCE_CYCLES must be >= 2.
// Ports:
//   clk       system clock
//   reset     asynchronous active-low reset
//   i_raw     raw input vector (asynchronous to clk)
//   o_data    committed (debounced) value
//   o_commit  high in the cycle whose closing edge commits a changed value
module io_debounce
  import io_input_ctrl_pkg::*;
#(
  parameter int   WIDTH           = 4,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic INVERT          = 1'b0
)(
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_data,
  output logic             o_commit
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // Counter value at which the next stable cycle completes the window
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 2);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] r_data;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_synced;
  logic             w_stable;
  logic             w_pending;

  // Polarity fix happens after the synchronizer so both flops see raw levels
  assign w_synced  = INVERT ? ~r_sync2 : r_sync2;
  assign w_stable  = (w_synced == r_cand);
  assign w_pending = (r_cand != r_data);
  assign o_commit  = w_stable && w_pending && (r_cnt == LAST);
  assign o_data    = r_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cand  <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (!w_stable) begin
        r_cand <= w_synced;
        r_cnt  <= '0;
      end else if (w_pending) begin
        // Counter stops at LAST; it is only cleared by a new candidate
        if (r_cnt == LAST) begin
          r_data <= r_cand;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/io_input_ctrl.sv
// io_input_ctrl
//   Memory-mapped input device for the single-cycle CPU. Debounces the
//   board keys (active-low, presented as pressed=1) and switches and
//   exposes a DATA and a CTRL/status register per bank.
//   CTRL: bit0 Ready (value changed, not yet read), bit2 Overrun (changed
//   again while Ready), bit4 IE (interrupt enable).
// Ports:
//   clk     system clock
//   reset   asynchronous active-low reset
//   KEY     raw keys, active-low
//   SW      raw switches, active-high
//   addr    bus byte address
//   rd_en   bus read strobe (DATA read clears Ready)
//   wr_en   bus write strobe (CTRL write clears flags / loads IE)
//   wdata   bus write data
//   rdata   combinational read data, 0 when no register is addressed
//   hit     addr selects one of the four registers
//   irq     OR over banks of Ready & IE
module io_input_ctrl
  import io_input_ctrl_pkg::*;
#(
  parameter int               DBITS           = DBITS_DEFAULT,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter logic [DBITS-1:0] ADDR_KDATA      = DBITS'(ADDR_KDATA_DEFAULT),
  parameter logic [DBITS-1:0] ADDR_KCTRL      = DBITS'(ADDR_KCTRL_DEFAULT),
  parameter logic [DBITS-1:0] ADDR_SDATA      = DBITS'(ADDR_SDATA_DEFAULT),
  parameter logic [DBITS-1:0] ADDR_SCTRL      = DBITS'(ADDR_SCTRL_DEFAULT)
)(
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  input  logic [DBITS-1:0] addr,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [DBITS-1:0] wdata,
  output logic [DBITS-1:0] rdata,
  output logic             hit,
  output logic             irq
);

  logic [3:0]        w_key_data;
  logic [9:0]        w_sw_data;
  logic [DBITS-1:0]  w_data [NBANKS];
  logic [DBITS-1:0]  w_ctrl [NBANKS];
  logic [NBANKS-1:0] w_commit;
  logic [NBANKS-1:0] w_hit_data;
  logic [NBANKS-1:0] w_hit_ctrl;
  logic [NBANKS-1:0] w_rd_data;
  logic [NBANKS-1:0] w_wr_ctrl;
  logic [NBANKS-1:0] w_clr_ready;
  logic [NBANKS-1:0] w_clr_ovr;
  logic [NBANKS-1:0] r_ready;
  logic [NBANKS-1:0] r_overrun;
  logic [NBANKS-1:0] r_ie;
  logic              w_unused_wdata;

  io_debounce #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .INVERT          (1'b1)
  ) u_key_debounce (
    .clk      (clk),
    .reset    (reset),
    .i_raw    (KEY),
    .o_data   (w_key_data),
    .o_commit (w_commit[BANK_KEY])
  );

  io_debounce #(
    .WIDTH           (10),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .INVERT          (1'b0)
  ) u_sw_debounce (
    .clk      (clk),
    .reset    (reset),
    .i_raw    (SW),
    .o_data   (w_sw_data),
    .o_commit (w_commit[BANK_SW])
  );

  assign w_data[BANK_KEY] = {{(DBITS-4){1'b0}}, w_key_data};
  assign w_data[BANK_SW]  = {{(DBITS-10){1'b0}}, w_sw_data};

  genvar gi;
  generate
    for (gi = 0; gi < NBANKS; gi++) begin : g_bank
      localparam logic [DBITS-1:0] DATA_ADDR = (gi == BANK_KEY) ? ADDR_KDATA : ADDR_SDATA;
      localparam logic [DBITS-1:0] CTRL_ADDR = (gi == BANK_KEY) ? ADDR_KCTRL : ADDR_SCTRL;
      ctrl_flags_t w_flags;

      assign w_hit_data[gi]  = (addr == DATA_ADDR);
      assign w_hit_ctrl[gi]  = (addr == CTRL_ADDR);
      assign w_rd_data[gi]   = rd_en & w_hit_data[gi];
      assign w_wr_ctrl[gi]   = wr_en & w_hit_ctrl[gi];
      // Flags are write-0-to-clear; a DATA read also acknowledges Ready
      assign w_clr_ready[gi] = w_rd_data[gi] | (w_wr_ctrl[gi] & ~wdata[READY_BIT]);
      assign w_clr_ovr[gi]   = w_wr_ctrl[gi] & ~wdata[OVERRUN_BIT];

      assign w_flags.ie      = r_ie[gi];
      assign w_flags.overrun = r_overrun[gi];
      assign w_flags.ready   = r_ready[gi];
      assign w_ctrl[gi]      = {{(DBITS-8){1'b0}}, ctrl_byte(w_flags)};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ready   <= '0;
      r_overrun <= '0;
      r_ie      <= '0;
    end else begin
      for (int b = 0; b < NBANKS; b++) begin
        if (w_wr_ctrl[b]) begin
          r_ie[b] <= wdata[IE_BIT];
        end
        if (w_clr_ovr[b]) begin
          r_overrun[b] <= 1'b0;
        end
        if (w_commit[b]) begin
          // A new value beats a same-cycle acknowledge, and since that
          // acknowledge consumed the old value it is not an overrun.
          r_ready[b] <= 1'b1;
          if (r_ready[b] && !w_clr_ready[b]) begin
            r_overrun[b] <= 1'b1;
          end
        end else if (w_clr_ready[b]) begin
          r_ready[b] <= 1'b0;
        end
      end
    end
  end

  // Addresses are distinct, so at most one source is selected
  always_comb begin
    rdata = '0;
    for (int b = 0; b < NBANKS; b++) begin
      if (w_hit_data[b]) rdata = w_data[b];
      if (w_hit_ctrl[b]) rdata = w_ctrl[b];
    end
  end

  assign hit = |{w_hit_data, w_hit_ctrl};
  assign irq = |(r_ready & r_ie);

  // Only the flag and IE bits of a CTRL write carry meaning
  assign w_unused_wdata = ^{wdata[DBITS-1:IE_BIT+1], wdata[IE_BIT-1:OVERRUN_BIT+1],
                            wdata[OVERRUN_BIT-1:READY_BIT+1]};

endmodule

// File: tb/tb_io_input_ctrl.sv
// tb_io_input_ctrl
//   Directed self-checking bench for io_input_ctrl with DEBOUNCE_CYCLES=4
//   (commit lands on the 6th clock edge after the raw input changes).
module tb_io_input_ctrl;

  localparam logic [31:0] A_KDATA = 32'hF000_0010;
  localparam logic [31:0] A_KCTRL = 32'hF000_0110;
  localparam logic [31:0] A_SDATA = 32'hF000_0014;
  localparam logic [31:0] A_SCTRL = 32'hF000_0114;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [31:0] addr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  io_input_ctrl #(
    .DBITS           (32),
    .DEBOUNCE_CYCLES (4),
    .ADDR_KDATA      (A_KDATA),
    .ADDR_KCTRL      (A_KCTRL),
    .ADDR_SDATA      (A_SDATA),
    .ADDR_SCTRL      (A_SCTRL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .KEY   (KEY),
    .SW    (SW),
    .addr  (addr),
    .rd_en (rd_en),
    .wr_en (wr_en),
    .wdata (wdata),
    .rdata (rdata),
    .hit   (hit),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; return 1 time unit after the edge
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Side-effect-free peek at a register (rd_en low)
  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    addr  = a;
    rd_en = 1'b0;
    #1;
    d = rdata;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b0;
    KEY = 4'hF; SW = 10'h0; addr = '0; rd_en = 0; wr_en = 0; wdata = '0;
    tick(2);
    peek(A_KDATA, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_kdata got=%h exp=%h", d, 32'h0); end
    checks++; if (hit !== 1'b1) begin failures++; $display("FAIL reset_hit_kdata got=%b exp=1", hit); end
    peek(A_KCTRL, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_kctrl got=%h exp=%h", d, 32'h0); end
    peek(A_SDATA, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_sdata got=%h exp=%h", d, 32'h0); end
    peek(A_SCTRL, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_sctrl got=%h exp=%h", d, 32'h0); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    $display("reset: regs cleared checked");
    tick();
    reset = 1'b1;
    tick(6);
  endtask

  task automatic test_sw_commit();
    logic [31:0] d;
    SW = 10'h155;
    tick(5);
    peek(A_SDATA, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL sw_early got=%h exp=%h", d, 32'h0); end
    tick();
    peek(A_SDATA, d);
    checks++; if (d !== 32'h155) begin failures++; $display("FAIL sw_sdata got=%h exp=%h", d, 32'h155); end
    peek(A_SCTRL, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL sw_sctrl got=%h exp=%h", d, 32'h1); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL sw_irq got=%b exp=0", irq); end
    $display("sw_commit: SW=155 committed after 6 cycles");
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    KEY = 4'b1110;
    tick(2);
    KEY = 4'hF;
    tick(8);
    peek(A_KDATA, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL glitch_kdata got=%h exp=%h", d, 32'h0); end
    peek(A_KCTRL, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL glitch_kctrl got=%h exp=%h", d, 32'h0); end
    $display("glitch: 2-cycle KEY pulse rejected");
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    KEY = 4'b1110;
    tick(6);
    peek(A_KDATA, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL ovr_press_kdata got=%h exp=%h", d, 32'h1); end
    peek(A_KCTRL, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL ovr_press_kctrl got=%h exp=%h", d, 32'h1); end
    KEY = 4'hF;
    tick(6);
    peek(A_KDATA, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL ovr_release_kdata got=%h exp=%h", d, 32'h0); end
    peek(A_KCTRL, d);
    checks++; if (d !== 32'h5) begin failures++; $display("FAIL ovr_kctrl got=%h exp=%h", d, 32'h5); end
    bus_write(A_KCTRL, 32'h0);
    peek(A_KCTRL, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL ovr_clear_kctrl got=%h exp=%h", d, 32'h0); end
    $display("overrun: KCTRL=5 then cleared by write");
  endtask

  task automatic test_irq();
    logic [31:0] d;
    bus_write(A_KCTRL, 32'h10);
    peek(A_KCTRL, d);
    checks++; if (d !== 32'h10) begin failures++; $display("FAIL irq_ie_kctrl got=%h exp=%h", d, 32'h10); end
    KEY = 4'b0111;
    tick(5);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_early got=%b exp=0", irq); end
    tick();
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_raised got=%b exp=1", irq); end
    addr  = A_KDATA;
    rd_en = 1'b1;
    #1;
    checks++; if (rdata !== 32'h8) begin failures++; $display("FAIL irq_read_kdata got=%h exp=%h", rdata, 32'h8); end
    tick();
    rd_en = 1'b0;
    peek(A_KCTRL, d);
    checks++; if (d !== 32'h10) begin failures++; $display("FAIL irq_after_read_kctrl got=%h exp=%h", d, 32'h10); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_after_read got=%b exp=0", irq); end
    $display("irq: raised on KEY3 commit, cleared by KDATA read");
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    KEY = 4'hF;
    tick(6);
    peek(A_KCTRL, d);
    checks++; if (d !== 32'h11) begin failures++; $display("FAIL b2b_ready_kctrl got=%h exp=%h", d, 32'h11); end
    KEY = 4'b1101;
    tick(5);
    // Read lands on the very edge that commits KDATA=2 while Ready is 1
    addr  = A_KDATA;
    rd_en = 1'b1;
    #1;
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL b2b_read_old got=%h exp=%h", rdata, 32'h0); end
    tick();
    rd_en = 1'b0;
    peek(A_KDATA, d);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL b2b_kdata got=%h exp=%h", d, 32'h2); end
    peek(A_KCTRL, d);
    checks++; if (d !== 32'h11) begin failures++; $display("FAIL b2b_kctrl got=%h exp=%h", d, 32'h11); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL b2b_irq got=%b exp=1", irq); end
    bus_write(A_KCTRL, 32'h0);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL b2b_irq_off got=%b exp=0", irq); end
    $display("back_to_back: commit wins over same-edge read, no overrun");
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    SW = 10'h3FF;
    tick(3);
    reset = 1'b0;
    #1;
    peek(A_SDATA, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rmid_sdata got=%h exp=%h", d, 32'h0); end
    peek(A_SCTRL, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rmid_sctrl got=%h exp=%h", d, 32'h0); end
    peek(A_KDATA, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rmid_kdata got=%h exp=%h", d, 32'h0); end
    tick(2);
    reset = 1'b1;
    tick(5);
    peek(A_SDATA, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL rmid_early got=%h exp=%h", d, 32'h0); end
    tick();
    peek(A_SDATA, d);
    checks++; if (d !== 32'h3FF) begin failures++; $display("FAIL rmid_sdata_after got=%h exp=%h", d, 32'h3FF); end
    peek(A_SCTRL, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL rmid_sctrl_after got=%h exp=%h", d, 32'h1); end
    addr = 32'h0;
    #1;
    checks++; if (hit !== 1'b0) begin failures++; $display("FAIL nohit_hit got=%b exp=0", hit); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL nohit_rdata got=%h exp=%h", rdata, 32'h0); end
    $display("reset_mid: SW=3FF re-debounced after reset");
  endtask

  initial begin
    test_reset();
    test_sw_commit();
    test_glitch();
    test_overrun();
    test_irq();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
